// File: rtl/l2d_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l2d_port_arbiter
// Description : Shares the single L2d request port among NUM_REQ L1d cache
//               controllers. Requesters are served round-robin. Within one
//               requester the op priority is write-back, then inclusion
//               write, then read/allocate. The winner's address, write word
//               and write-back line are latched. The arbiter drives the L2d
//               handshake and returns a one-cycle done pulse, plus the read
//               line, to the owner only.
//
//               The FSM runs IDLE -> ISSUE -> RELEASE -> IDLE. Every output
//               is registered.
//
// Ports       : clk, reset            clock, asynchronous active-high reset
//               req_rd/req_wr/req_wb  per-requester level requests
//               req_addr/req_wdata/req_line
//                                     packed per-requester buses; requester i
//                                     sits at [i*W +: W]
//               gnt                   one-hot current owner, 0 when idle
//               done                  one-cycle completion pulse to the owner
//               rd_line               last completed L2d read line
//               l2_rd_req/l2_wr_req/l2_wb_req
//                                     L2d requests, at most one high
//               l2_addr/l2_wdata/l2_line
//                                     latched owner buses
//               l2_rd_done/l2_wr_done/l2_wb_done
//                                     L2d completions
//               l2_rdata              L2d read line, sampled with l2_rd_done
//
// Config      : L2D_ARB_WB_PRIORITY_EN. When this macro is defined, any
//               write-back requester beats all rd/wr requesters in IDLE.
//               Round-robin is applied among the wb requesters first, then
//               among the rest.
//
// Revision    : 1.0 - initial release
// ============================================================================
module l2d_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int WORD_W  = 32,
    parameter int LINE_W  = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_rd,
    input  logic [NUM_REQ-1:0]          req_wr,
    input  logic [NUM_REQ-1:0]          req_wb,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*WORD_W-1:0]   req_wdata,
    input  logic [NUM_REQ*LINE_W-1:0]   req_line,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic [LINE_W-1:0]           rd_line,
    output logic                        l2_rd_req,
    output logic                        l2_wr_req,
    output logic                        l2_wb_req,
    output logic [ADDR_W-1:0]           l2_addr,
    output logic [WORD_W-1:0]           l2_wdata,
    output logic [LINE_W-1:0]           l2_line,
    input  logic                        l2_rd_done,
    input  logic                        l2_wr_done,
    input  logic                        l2_wb_done,
    input  logic [LINE_W-1:0]           l2_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    // Op vectors are one-hot {wb, wr, rd}, matching the L2d request bits.
    localparam int OP_RD = 0;
    localparam int OP_WR = 1;
    localparam int OP_WB = 2;

    // Returns {found, index} of the first set bit at or after ptr, wrapping.
    // The scan runs from the farthest candidate to the nearest one, so the
    // nearest set bit is written last and wins.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] idx;
        rr_pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + IDX_W'(i);
            if (vec[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    w_owner_nxt;
    logic [2:0]          r_op;
    logic [2:0]          w_op_nxt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [NUM_REQ-1:0]  r_done;
    logic [NUM_REQ-1:0]  w_done_nxt;
    logic [2:0]          r_l2_req;
    logic [2:0]          w_l2_req_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [WORD_W-1:0]   r_wdata;
    logic [WORD_W-1:0]   w_wdata_nxt;
    logic [LINE_W-1:0]   r_line;
    logic [LINE_W-1:0]   w_line_nxt;
    logic [LINE_W-1:0]   r_rd_line;
    logic [LINE_W-1:0]   w_rd_line_nxt;

    logic [NUM_REQ-1:0]  w_pending;
    logic [IDX_W:0]      w_sel;
    logic                w_found;
    logic [IDX_W-1:0]    w_idx;
    logic [2:0]          w_pick_op;
    logic                w_match;
    logic                w_op_clear;

    assign w_pending = req_rd | req_wr | req_wb;

`ifdef L2D_ARB_WB_PRIORITY_EN
    logic [IDX_W:0] w_sel_wb;
    assign w_sel_wb = rr_pick(req_wb, r_ptr);
    assign w_sel    = w_sel_wb[IDX_W] ? w_sel_wb : rr_pick(w_pending, r_ptr);
`else
    assign w_sel    = rr_pick(w_pending, r_ptr);
`endif

    assign w_found = w_sel[IDX_W];
    assign w_idx   = w_sel[IDX_W-1:0];

    // Op priority within the chosen requester: wb > wr > rd.
    always_comb begin
        w_pick_op = 3'b000;
        if (req_wb[w_idx]) begin
            w_pick_op[OP_WB] = 1'b1;
        end else if (req_wr[w_idx]) begin
            w_pick_op[OP_WR] = 1'b1;
        end else begin
            w_pick_op[OP_RD] = 1'b1;
        end
    end

    // Only the completion that matches the issued op is honoured.
    assign w_match    = |(r_op & {l2_wb_done, l2_wr_done, l2_rd_done});
    // The owner releases once the request bit it was serviced for is low.
    assign w_op_clear = ~|(r_op & {req_wb[r_owner], req_wr[r_owner], req_rd[r_owner]});

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_found)    w_state_nxt = S_ISSUE;
            S_ISSUE:   if (w_match)    w_state_nxt = S_RELEASE;
            S_RELEASE: if (w_op_clear) w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output and datapath next values (registered below)
    // ------------------------------------------------------------------
    always_comb begin
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_op_nxt      = r_op;
        w_gnt_nxt     = r_gnt;
        w_done_nxt    = '0;
        w_l2_req_nxt  = r_l2_req;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_line_nxt    = r_line;
        w_rd_line_nxt = r_rd_line;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_owner_nxt  = w_idx;
                    w_op_nxt     = w_pick_op;
                    w_gnt_nxt    = NUM_REQ'(1) << w_idx;
                    w_l2_req_nxt = w_pick_op;
                    w_addr_nxt   = req_addr[w_idx*ADDR_W +: ADDR_W];
                    w_wdata_nxt  = req_wdata[w_idx*WORD_W +: WORD_W];
                    w_line_nxt   = req_line[w_idx*LINE_W +: LINE_W];
                end
            end
            S_ISSUE: begin
                if (w_match) begin
                    w_l2_req_nxt = 3'b000;
                    w_done_nxt   = r_gnt;
                    if (r_op[OP_RD]) begin
                        w_rd_line_nxt = l2_rdata;
                    end
                end
            end
            S_RELEASE: begin
                if (w_op_clear) begin
                    w_gnt_nxt = '0;
                    w_ptr_nxt = r_owner + IDX_W'(1);
                end
            end
            default: begin
                w_gnt_nxt    = '0;
                w_l2_req_nxt = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr     <= '0;
            r_owner   <= '0;
            r_op      <= 3'b000;
            r_gnt     <= '0;
            r_done    <= '0;
            r_l2_req  <= 3'b000;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_line    <= '0;
            r_rd_line <= '0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_op      <= w_op_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_l2_req  <= w_l2_req_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_line    <= w_line_nxt;
            r_rd_line <= w_rd_line_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign rd_line   = r_rd_line;
    assign l2_rd_req = r_l2_req[OP_RD];
    assign l2_wr_req = r_l2_req[OP_WR];
    assign l2_wb_req = r_l2_req[OP_WB];
    assign l2_addr   = r_addr;
    assign l2_wdata  = r_wdata;
    assign l2_line   = r_line;

endmodule
`default_nettype wire

// File: tb/tb_l2d_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2d_port_arbiter
// Description : Directed self-checking bench for l2d_port_arbiter with
//               NUM_REQ=4. The bench plays the role of the L1d requesters
//               and of the L2d.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2d_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int WORD_W  = 32;
    localparam int LINE_W  = 256;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_rd, req_wr, req_wb;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*WORD_W-1:0] req_wdata;
    logic [NUM_REQ*LINE_W-1:0] req_line;
    logic [NUM_REQ-1:0]        gnt, done;
    logic [LINE_W-1:0]         rd_line;
    logic                      l2_rd_req, l2_wr_req, l2_wb_req;
    logic [ADDR_W-1:0]         l2_addr;
    logic [WORD_W-1:0]         l2_wdata;
    logic [LINE_W-1:0]         l2_line;
    logic                      l2_rd_done, l2_wr_done, l2_wb_done;
    logic [LINE_W-1:0]         l2_rdata;

    int total = 0;
    int bad   = 0;

    logic [LINE_W-1:0] line_ab;
    logic [LINE_W-1:0] line_5a;
    logic [LINE_W-1:0] line_c3;
    logic [NUM_REQ-1:0] exp_wb_owner;

    l2d_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .WORD_W  (WORD_W),
        .LINE_W  (LINE_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_wb     (req_wb),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_line   (req_line),
        .gnt        (gnt),
        .done       (done),
        .rd_line    (rd_line),
        .l2_rd_req  (l2_rd_req),
        .l2_wr_req  (l2_wr_req),
        .l2_wb_req  (l2_wb_req),
        .l2_addr    (l2_addr),
        .l2_wdata   (l2_wdata),
        .l2_line    (l2_line),
        .l2_rd_done (l2_rd_done),
        .l2_wr_done (l2_wr_done),
        .l2_wb_done (l2_wb_done),
        .l2_rdata   (l2_rdata)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        line_ab = {32{8'hAB}};
        line_5a = {32{8'h5A}};
        line_c3 = {32{8'hC3}};
        reset = 1'b1;
        req_rd = '0; req_wr = '0; req_wb = '0;
        req_addr = '0; req_wdata = '0; req_line = '0;
        l2_rd_done = 1'b0; l2_wr_done = 1'b0; l2_wb_done = 1'b0;
        l2_rdata = '0;
        step();
        step();
        chk("reset_gnt",     LINE_W'(gnt), '0);
        chk("reset_done",    LINE_W'(done), '0);
        chk("reset_reqs",    LINE_W'({l2_wb_req, l2_wr_req, l2_rd_req}), '0);
        chk("reset_rd_line", rd_line, '0);
        chk("reset_addr",    LINE_W'(l2_addr), '0);
        reset = 1'b0;
        step();
        chk("idle_gnt", LINE_W'(gnt), '0);

        // Single read from requester 2.
        req_addr[2*ADDR_W +: ADDR_W] = 32'hC000_0040;
        req_rd = 4'b0100;
        step();
        chk("t1_gnt",     LINE_W'(gnt), LINE_W'(4'b0100));
        chk("t1_addr",    LINE_W'(l2_addr), LINE_W'(32'hC000_0040));
        chk("t1_rdreq_0", LINE_W'(l2_rd_req), LINE_W'(1'b1));
        step();
        chk("t1_rdreq_1", LINE_W'(l2_rd_req), LINE_W'(1'b1));
        step();
        chk("t1_rdreq_2", LINE_W'(l2_rd_req), LINE_W'(1'b1));
        chk("t1_done_lo", LINE_W'(done), '0);
        l2_rd_done = 1'b1;
        l2_rdata   = line_ab;
        step();
        l2_rd_done = 1'b0;
        l2_rdata   = '0;
        chk("t1_done",    LINE_W'(done), LINE_W'(4'b0100));
        chk("t1_rdreq_x", LINE_W'(l2_rd_req), '0);
        chk("t1_rd_line", rd_line, line_ab);
        chk("t1_gnt_hold", LINE_W'(gnt), LINE_W'(4'b0100));
        req_rd = 4'b0000;
        step();
        chk("t1_done_pulse", LINE_W'(done), '0);
        chk("t1_gnt_rel",    LINE_W'(gnt), '0);

        // Contention: all four requesters read; order 0,1,2,3,0.
        do_reset();
        req_rd = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("t2_gnt_%0d", k), LINE_W'(gnt), LINE_W'(4'b0001 << (k % 4)));
            chk($sformatf("t2_req_%0d", k), LINE_W'(l2_rd_req), LINE_W'(1'b1));
            step();
            l2_rd_done = 1'b1;
            l2_rdata   = line_c3;
            step();
            l2_rd_done = 1'b0;
            chk($sformatf("t2_done_%0d", k), LINE_W'(done), LINE_W'(4'b0001 << (k % 4)));
            req_rd[k % 4] = 1'b0;
            step();
            chk($sformatf("t2_rel_%0d", k), LINE_W'(gnt), '0);
            if (k < 4) req_rd[k % 4] = 1'b1;
        end
        req_rd = 4'b0000;
        chk("t2_rd_line", rd_line, line_c3);

        // Op priority inside requester 1: wb served before rd.
        req_line[1*LINE_W +: LINE_W] = line_5a;
        req_rd = 4'b0010;
        req_wb = 4'b0010;
        step();
        chk("t3_gnt",   LINE_W'(gnt), LINE_W'(4'b0010));
        chk("t3_reqs",  LINE_W'({l2_wb_req, l2_wr_req, l2_rd_req}), LINE_W'(3'b100));
        chk("t3_line",  l2_line, line_5a);
        step();
        l2_wb_done = 1'b1;
        step();
        l2_wb_done = 1'b0;
        chk("t3_wb_done", LINE_W'(done), LINE_W'(4'b0010));
        chk("t3_rd_line_hold", rd_line, line_c3);
        req_wb = 4'b0000;
        step();
        chk("t3_rel", LINE_W'(gnt), '0);
        step();
        chk("t3_gnt_rd",  LINE_W'(gnt), LINE_W'(4'b0010));
        chk("t3_reqs_rd", LINE_W'({l2_wb_req, l2_wr_req, l2_rd_req}), LINE_W'(3'b001));
        l2_rd_done = 1'b1;
        l2_rdata   = line_ab;
        step();
        l2_rd_done = 1'b0;
        chk("t3_rd_line", rd_line, line_ab);
        req_rd = 4'b0000;
        step();

        // Write-back priority: pointer 0, rd on 0 and wb on 3.
`ifdef L2D_ARB_WB_PRIORITY_EN
        exp_wb_owner = 4'b1000;
`else
        exp_wb_owner = 4'b0001;
`endif
        do_reset();
        req_rd = 4'b0001;
        req_wb = 4'b1000;
        step();
        chk("t4_gnt", LINE_W'(gnt), LINE_W'(exp_wb_owner));
        l2_rd_done = 1'b1;
        l2_wb_done = 1'b1;
        step();
        l2_rd_done = 1'b0;
        l2_wb_done = 1'b0;
        chk("t4_done", LINE_W'(done), LINE_W'(exp_wb_owner));
        req_rd = 4'b0000;
        req_wb = 4'b0000;
        step();
        chk("t4_rel", LINE_W'(gnt), '0);

        // Abort: requester 1 drops its write mid-ISSUE; mismatched done ignored.
        req_addr[1*ADDR_W +: ADDR_W]  = 32'h0000_1F00;
        req_wdata[1*WORD_W +: WORD_W] = 32'h1234_5678;
        req_wr = 4'b0010;
        step();
        chk("t5_gnt",   LINE_W'(gnt), LINE_W'(4'b0010));
        chk("t5_wdata", LINE_W'(l2_wdata), LINE_W'(32'h1234_5678));
        chk("t5_addr",  LINE_W'(l2_addr), LINE_W'(32'h0000_1F00));
        req_wr = 4'b0000;
        step();
        chk("t5_wrreq_held", LINE_W'(l2_wr_req), LINE_W'(1'b1));
        l2_rd_done = 1'b1;
        step();
        l2_rd_done = 1'b0;
        chk("t6_mismatch_req",  LINE_W'(l2_wr_req), LINE_W'(1'b1));
        chk("t6_mismatch_done", LINE_W'(done), '0);
        step();
        chk("t6_still_issue", LINE_W'(l2_wr_req), LINE_W'(1'b1));
        l2_wr_done = 1'b1;
        step();
        l2_wr_done = 1'b0;
        chk("t5_done",    LINE_W'(done), LINE_W'(4'b0010));
        chk("t5_wrreq_x", LINE_W'(l2_wr_req), '0);
        step();
        chk("t5_rel", LINE_W'(gnt), '0);

        // Reset mid-ISSUE: pointer is 2, so requester 3 wins first.
        req_rd = 4'b1010;
        step();
        chk("t5r_gnt", LINE_W'(gnt), LINE_W'(4'b1000));
        #2;
        reset = 1'b1;
        #1;
        chk("t5r_gnt_async",   LINE_W'(gnt), '0);
        chk("t5r_rdreq_async", LINE_W'(l2_rd_req), '0);
        chk("t5r_addr_async",  LINE_W'(l2_addr), '0);
        step();
        reset = 1'b0;
        step();
        chk("t5r_gnt_ptr0", LINE_W'(gnt), LINE_W'(4'b0010));
        req_rd = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
